cpu: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_if.sv | 28 ++
 rtl/cpu_alu_add.sv | 18 +
 rtl/cpu.sv | 131 +++++++++++++
 tb/tb_cpu.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU.
// Holds the data width, the opcode enum and the datapath source select.
package cpu_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_A,
        SRC_B,
        SRC_SW,
        SRC_ZERO
    } src_e;

endpackage

// File: rtl/cpu_if.sv
// Board-side bus of the CPU: ROM instruction fields, switch input,
// ROM address and LED output. master = CPU, slave = ROM/board.
interface cpu_if;
    import cpu_pkg::*;

    logic [3:0]       opecode;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] led;

    modport master (
        input  opecode,
        input  imm,
        input  switch,
        output addr,
        output led
    );

    modport slave (
        output opecode,
        output imm,
        output switch,
        input  addr,
        input  led
    );

endinterface

// File: rtl/cpu_alu_add.sv
// 4-bit adder with carry-out used as the CPU's only datapath element.
// Ports: a, b (operands), sum (low 4 bits), cout (bit 4 of the sum).
module alu_add
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/cpu.sv
// Single-cycle 4-bit CPU: registers A, B, OUT, PC and carry flag C.
// Ports: clk, n_rst (async active-low), bus (cpu_if.master).
module cpu
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  n_rst,
    cpu_if.master bus
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_out;
    logic [WIDTH-1:0] pc;
    logic             carry;

    src_e             src_sel;
    logic             ld_a;
    logic             ld_b;
    logic             ld_out;
    logic             jump;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Undefined opcodes fall to the default: nothing loads, and the
    // zero source keeps the adder carry (and so C) at 0.
    always_comb begin
        src_sel = SRC_ZERO;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_out  = 1'b0;
        jump    = 1'b0;
        case (opcode_e'(bus.opecode))
            OP_ADD_A: begin
                src_sel = SRC_A;
                ld_a    = 1'b1;
            end
            OP_MOV_AB: begin
                src_sel = SRC_B;
                ld_a    = 1'b1;
            end
            OP_IN_A: begin
                src_sel = SRC_SW;
                ld_a    = 1'b1;
            end
            OP_MOV_AI: begin
                ld_a    = 1'b1;
            end
            OP_MOV_BA: begin
                src_sel = SRC_A;
                ld_b    = 1'b1;
            end
            OP_ADD_B: begin
                src_sel = SRC_B;
                ld_b    = 1'b1;
            end
            OP_IN_B: begin
                src_sel = SRC_SW;
                ld_b    = 1'b1;
            end
            OP_MOV_BI: begin
                ld_b    = 1'b1;
            end
            OP_OUT_B: begin
                src_sel = SRC_B;
                ld_out  = 1'b1;
            end
            OP_OUT_I: begin
                ld_out  = 1'b1;
            end
            // JNC looks at the flag left by the previous instruction.
            OP_JNC: begin
                jump    = ~carry;
            end
            OP_JMP: begin
                jump    = 1'b1;
            end
            default: begin
                src_sel = SRC_ZERO;
            end
        endcase
    end

    always_comb begin
        src = '0;
        case (src_sel)
            SRC_A:    src = reg_a;
            SRC_B:    src = reg_b;
            SRC_SW:   src = bus.switch;
            default:  src = '0;
        endcase
    end

    alu_add u_alu (
        .a    (src),
        .b    (bus.imm),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_out <= '0;
            pc      <= '0;
            carry   <= 1'b0;
        end else begin
            carry <= cout;
            if (ld_a) begin
                reg_a <= sum;
            end
            if (ld_b) begin
                reg_b <= sum;
            end
            if (ld_out) begin
                reg_out <= sum;
            end
            if (jump) begin
                pc <= sum;
            end else begin
                pc <= pc + WIDTH'(1);
            end
        end
    end

    assign bus.addr = pc;
    assign bus.led  = reg_out;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random instructions
// against a behavioural model; addr/led compared on every falling edge.
module tb_cpu;

    logic clk;
    logic n_rst;

    cpu_if bus ();

    cpu dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    int ma = 0;
    int mb = 0;
    int mo = 0;
    int mp = 0;
    int mc = 0;

    task automatic model_exec(input int op, input int im, input int sw);
        int r;
        int np;
        r  = 0;
        np = (mp + 1) % 16;
        if (!n_rst) begin
            ma = 0; mb = 0; mo = 0; mp = 0; mc = 0;
            return;
        end
        case (op)
            0:  begin r = ma + im; ma = r % 16; end
            1:  begin r = mb + im; ma = r % 16; end
            2:  begin r = sw + im; ma = r % 16; end
            3:  begin r = im;      ma = r; end
            4:  begin r = ma + im; mb = r % 16; end
            5:  begin r = mb + im; mb = r % 16; end
            6:  begin r = sw + im; mb = r % 16; end
            7:  begin r = im;      mb = r; end
            9:  begin r = mb + im; mo = r % 16; end
            11: begin r = im;      mo = r; end
            14: begin r = im; if (mc == 0) np = im; end
            15: begin r = im; np = im; end
            default: r = 0;
        endcase
        mc = r / 16;
        mp = np;
    endtask

    task automatic step(input int op, input int im, input int sw);
        bus.opecode = 4'(op);
        bus.imm     = 4'(im);
        bus.switch  = 4'(sw);
        @(posedge clk);
        model_exec(op, im, sw);
        #1;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (int'(bus.addr) != mp || int'(bus.led) != mo) begin
            n_err++;
            $display("FAIL model t=%0t: addr=%0d led=%0d expected addr=%0d led=%0d",
                     $time, bus.addr, bus.led, mp, mo);
        end
    end

    task automatic async_reset_pulse();
        n_rst = 1'b0;
        #1;
        ma = 0; mb = 0; mo = 0; mp = 0; mc = 0;
        lit("async_rst_addr", int'(bus.addr), 0);
        lit("async_rst_led", int'(bus.led), 0);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst       = 1'b0;
        bus.opecode = 4'd0;
        bus.imm     = 4'd0;
        bus.switch  = 4'd0;
        #2;
        lit("rst_addr", int'(bus.addr), 0);
        lit("rst_led", int'(bus.led), 0);
        step(0, 0, 0);
        step(0, 0, 0);
        lit("rst_hold_addr", int'(bus.addr), 0);
        n_rst = 1'b1;

        step(0, 0, 0);
        lit("step_addr1", int'(bus.addr), 1);
        step(0, 0, 0);
        lit("step_addr2", int'(bus.addr), 2);
        step(0, 0, 0);
        lit("step_addr3", int'(bus.addr), 3);

        step(2, 0, 3);
        step(4, 0, 0);
        step(9, 0, 0);
        lit("in_a_out_b_led", int'(bus.led), 3);
        step(6, 0, 6);
        step(9, 0, 0);
        lit("in_b_out_b_led", int'(bus.led), 6);
        lit("addr_before_add", int'(bus.addr), 8);

        step(3, 10, 0);
        step(0, 10, 0);
        step(14, 7, 0);
        lit("jnc_not_taken", int'(bus.addr), 11);
        step(14, 7, 0);
        lit("jnc_taken", int'(bus.addr), 7);
        step(4, 0, 0);
        step(9, 0, 0);
        lit("add_wrap_a4", int'(bus.led), 4);
        lit("addr_at_9", int'(bus.addr), 9);

        step(15, 3, 0);
        lit("jmp_3", int'(bus.addr), 3);
        for (int i = 0; i < 12; i++) step(8, 0, 0);
        lit("addr_15", int'(bus.addr), 15);
        step(8, 0, 0);
        lit("pc_wrap", int'(bus.addr), 0);

        step(11, 5, 0);
        lit("out_imm5", int'(bus.led), 5);
        step(8, 9, 9);
        lit("nop_led", int'(bus.led), 5);
        lit("nop_pc", int'(bus.addr), 2);

        async_reset_pulse();
        step(0, 0, 0);
        lit("restart_addr", int'(bus.addr), 1);

        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if ((op == 14 || op == 15) && $urandom_range(0, 3) != 0)
                op = int'($urandom_range(0, 11));
            step(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 63) == 0) async_reset_pulse();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
